// File: rtl/asynch_uart_pkg.sv
// Purpose: shared UART constants, state encoding and parity helper for the asynch receiver/sender pair.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package asynch_uart_pkg;

   // 50 MHz core clock / 9600 bit/s
   localparam logic [15:0] DIVIDER_DEFAULT = 16'd5208;
   localparam int          DATA_BITS       = 8;

   // Declaration order follows the frame: IDLE, START, DATA, PARITY, STOP
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   // Even-parity bit: the value that makes the total count of ones even
   function automatic logic even_parity(input logic [DATA_BITS-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/asynch_rx_sync.sv
// Purpose: two-flop synchroniser bringing the asynchronous serial line into the clk domain.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
// Ports: clk (clock), rst_n (sync active-low reset, flops load RST_VAL), d (async input), q (synchronised output).
module asynch_rx_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/asynch_receiver.sv
// Purpose: 8N1 UART receiver (optional even parity when ASYNCH_RX_PARITY_EN is defined).
// Latency: result pulse one cycle after the mid-stop-bit sample (~2 + DIVIDER/2 + 9*DIVIDER cycles from start edge, +DIVIDER with parity).
// Backpressure: none; valid/frame_err/parity_err are single-cycle pulses that must be captured when seen.
// Ports: clk, rst_n (sync active-low), D (async serial line, idle high), data (last good byte),
//        valid (data updated), frame_err (stop bit low), parity_err (parity mismatch, 0 without macro), busy (FSM not idle).
module asynch_receiver
   import asynch_uart_pkg::*;
#(
   parameter logic [15:0] DIVIDER = DIVIDER_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       D,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam logic [15:0] HALF_LAST = (DIVIDER >> 1) - 16'd1;
   localparam logic [15:0] FULL_LAST = DIVIDER - 16'd1;
   localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);

   logic                 rx_s;
   logic                 rx_prev;
   uart_state_t          state;
   logic [15:0]          tick_cnt;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shift;
   logic                 par_bad;

   asynch_rx_sync #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (D),
      .q     (rx_s)
   );

`ifdef ASYNCH_RX_PARITY_EN
   logic par_bit;
   logic perr_q;
   assign par_bad    = even_parity(shift) ^ par_bit;
   assign parity_err = perr_q;
`else
   assign par_bad    = 1'b0;
   assign parity_err = 1'b0;
`endif

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_prev   <= 1'b1;
         state     <= ST_IDLE;
         tick_cnt  <= 16'd0;
         bit_cnt   <= 4'd0;
         shift     <= '0;
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
`ifdef ASYNCH_RX_PARITY_EN
         par_bit   <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         rx_prev   <= rx_s;
         valid     <= 1'b0;
         frame_err <= 1'b0;
`ifdef ASYNCH_RX_PARITY_EN
         perr_q    <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               tick_cnt <= 16'd0;
               bit_cnt  <= 4'd0;
               // Only a true 1->0 transition starts a frame, so a held-low
               // break line cannot retrigger until it has gone high again.
               if (rx_prev && !rx_s)
                  state <= ST_START;
            end
            ST_START: begin
               if (tick_cnt == HALF_LAST) begin
                  tick_cnt <= 16'd0;
                  // Line back high at mid-start means a glitch: drop silently
                  state    <= rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  tick_cnt <= tick_cnt + 16'd1;
               end
            end
            ST_DATA: begin
               if (tick_cnt == FULL_LAST) begin
                  tick_cnt              <= 16'd0;
                  shift[bit_cnt[2:0]]   <= rx_s;
                  bit_cnt               <= bit_cnt + 4'd1;
                  if (bit_cnt == LAST_BIT) begin
`ifdef ASYNCH_RX_PARITY_EN
                     state <= ST_PARITY;
`else
                     state <= ST_STOP;
`endif
                  end
               end else begin
                  tick_cnt <= tick_cnt + 16'd1;
               end
            end
            ST_PARITY: begin
`ifdef ASYNCH_RX_PARITY_EN
               if (tick_cnt == FULL_LAST) begin
                  tick_cnt <= 16'd0;
                  par_bit  <= rx_s;
                  state    <= ST_STOP;
               end else begin
                  tick_cnt <= tick_cnt + 16'd1;
               end
`else
               state <= ST_IDLE;
`endif
            end
            ST_STOP: begin
               if (tick_cnt == FULL_LAST) begin
                  tick_cnt  <= 16'd0;
                  state     <= ST_IDLE;
                  frame_err <= !rx_s;
`ifdef ASYNCH_RX_PARITY_EN
                  perr_q    <= par_bad;
`endif
                  // data and valid change on the same edge
                  if (rx_s && !par_bad) begin
                     valid <= 1'b1;
                     data  <= shift;
                  end
               end else begin
                  tick_cnt <= tick_cnt + 16'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_asynch_receiver.sv
// Purpose: self-checking bench for asynch_receiver with DIVIDER=16 (directed table, corner sequences, random frames).
// Latency: n/a.
// Backpressure: n/a.
module tb_asynch_receiver;

   localparam int DIV = 16;
`ifdef ASYNCH_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       d_line = 1'b1;
   logic [7:0] data;
   logic       valid, frame_err, parity_err, busy;

   asynch_receiver #(.DIVIDER(16'd16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .D          (d_line),
      .data       (data),
      .valid      (valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      bit         v;
      bit         fe;
      bit         pe;
      logic [7:0] d;
      int         cyc;
   } ev_t;
   ev_t ev_q[$];

   typedef struct {
      logic [7:0] d;
      bit         stop;
      bit         pflip;
      int         hold;
      int         gap;
      bit         ev;
      bit         efe;
      bit         epe;
   } vec_t;
   vec_t vq[$];

   logic [7:0] last_good = 8'h00;
   bit prev_v = 0, prev_fe = 0, prev_pe = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: logs every output pulse and flags any lasting > 1 cycle
   always @(negedge clk) begin
      if (valid || frame_err || parity_err) begin
         ev_q.push_back('{valid, frame_err, parity_err, data, cyc});
         checks++;
         if ((valid && prev_v) || (frame_err && prev_fe) || (parity_err && prev_pe)) begin
            failures++;
            $display("FAIL pulse_width: got v=%0b fe=%0b pe=%0b two cycles running, expected single-cycle pulses",
                     valid, frame_err, parity_err);
         end
      end
      prev_v  = valid;
      prev_fe = frame_err;
      prev_pe = parity_err;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference rule: stop low -> frame error; parity mismatch -> parity error;
   // a byte is delivered only if both are good.
   task automatic model(input logic [7:0] dv, input bit stop, input bit pflip,
                        output bit ev, output bit efe, output bit epe);
      bit bad_par;
`ifdef ASYNCH_RX_PARITY_EN
      bad_par = pflip;
`else
      bad_par = 1'b0;
`endif
      efe = !stop;
      epe = bad_par;
      ev  = stop && !bad_par;
   endtask

   task automatic run_frame(input logic [7:0] dv, input bit stop, input bit pflip,
                            input int hold, input int gap,
                            input bit ev, input bit efe, input bit epe);
      int t0;
      int lat;
      bit busy_seen;
      ev_t e;
      ev_q.delete();
      t0 = cyc;
      d_line = 1'b0;
      tick(DIV);
      for (int i = 0; i < 8; i++) begin
         d_line = dv[i];
         tick(DIV);
      end
`ifdef ASYNCH_RX_PARITY_EN
      d_line = (^dv) ^ pflip;
      tick(DIV);
`endif
      d_line = stop;
      tick(DIV);
      busy_seen = 1'b0;
      for (int i = 0; i < hold; i++) begin
         d_line = 1'b0;
         tick(1);
         if (busy) busy_seen = 1'b1;
      end
      if (hold > 0) check("break_no_restart_busy", {31'd0, busy_seen}, 32'd0);
      d_line = 1'b1;
      tick(gap);
      check("event_count", ev_q.size(), 32'd1);
      if (ev_q.size() > 0) begin
         e = ev_q[0];
         lat = e.cyc - t0;
         check("valid_pulse", {31'd0, e.v}, {31'd0, ev});
         check("frame_err_pulse", {31'd0, e.fe}, {31'd0, efe});
         check("parity_err_pulse", {31'd0, e.pe}, {31'd0, epe});
         check("pulse_latency_in_window",
               {31'd0, (lat <= DIV * NBITS) && (lat >= DIV * (NBITS - 1))}, 32'd1);
         if (ev) check("data_at_valid", {24'd0, e.d}, {24'd0, dv});
      end
      if (ev) last_good = dv;
      check("data_held", {24'd0, data}, {24'd0, last_good});
   endtask

   initial begin
      vec_t v;
      logic [7:0] rd;
      bit rs, rp, xv, xfe, xpe;
      int rg;

      // Directed vectors: {data, stop, parity flip, break hold, idle gap, exp valid, exp frame_err, exp parity_err}
      vq.push_back(vec_t'{8'hA5, 1'b1, 1'b0, 0, 4, 1'b1, 1'b0, 1'b0});
      vq.push_back(vec_t'{8'h00, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0});
      vq.push_back(vec_t'{8'hFF, 1'b1, 1'b0, 0, 6, 1'b1, 1'b0, 1'b0});
      vq.push_back(vec_t'{8'h3C, 1'b0, 1'b0, 40, 20, 1'b0, 1'b1, 1'b0});
      vq.push_back(vec_t'{8'h81, 1'b1, 1'b0, 0, 3, 1'b1, 1'b0, 1'b0});
`ifdef ASYNCH_RX_PARITY_EN
      vq.push_back(vec_t'{8'h01, 1'b1, 1'b1, 0, 4, 1'b0, 1'b0, 1'b1});
      vq.push_back(vec_t'{8'h01, 1'b1, 1'b0, 0, 4, 1'b1, 1'b0, 1'b0});
      vq.push_back(vec_t'{8'hC3, 1'b0, 1'b1, 0, 6, 1'b0, 1'b1, 1'b1});
`endif

      // Reset state
      rst_n = 1'b0;
      tick(3);
      check("reset_data", {24'd0, data}, 32'd0);
      check("reset_valid", {31'd0, valid}, 32'd0);
      check("reset_frame_err", {31'd0, frame_err}, 32'd0);
      check("reset_parity_err", {31'd0, parity_err}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      tick(5);

      foreach (vq[i]) begin
         v = vq[i];
         run_frame(v.d, v.stop, v.pflip, v.hold, v.gap, v.ev, v.efe, v.epe);
      end

      // Short glitch on the line: no output, FSM idle again quickly
      ev_q.delete();
      d_line = 1'b0;
      tick(4);
      d_line = 1'b1;
      tick(8);
      check("glitch_busy_cleared", {31'd0, busy}, 32'd0);
      tick(8);
      check("glitch_no_pulse", ev_q.size(), 32'd0);

      // Reset during data bit 3 of 8'h5A
      ev_q.delete();
      rd = 8'h5A;
      d_line = 1'b0;
      tick(DIV);
      for (int i = 0; i < 3; i++) begin
         d_line = rd[i];
         tick(DIV);
      end
      d_line = rd[3];
      tick(DIV / 2);
      rst_n = 1'b0;
      tick(2);
      check("midframe_reset_data", {24'd0, data}, 32'd0);
      check("midframe_reset_busy", {31'd0, busy}, 32'd0);
      check("midframe_reset_valid", {31'd0, valid}, 32'd0);
      check("midframe_reset_frame_err", {31'd0, frame_err}, 32'd0);
      rst_n = 1'b1;
      last_good = 8'h00;
      d_line = 1'b1;
      tick(2 * DIV);
      check("midframe_reset_no_pulse", ev_q.size(), 32'd0);
      run_frame(8'h5A, 1'b1, 1'b0, 0, 4, 1'b1, 1'b0, 1'b0);

      // Random frames against the reference rule
      for (int n = 0; n < 20; n++) begin
         rd = 8'($urandom);
         rs = ($urandom_range(0, 5) != 0);
         rp = ($urandom_range(0, 3) == 0);
         rg = rs ? $urandom_range(0, 4) : $urandom_range(3, 6);
         model(rd, rs, rp, xv, xfe, xpe);
         run_frame(rd, rs, rp, 0, rg, xv, xfe, xpe);
      end

      tick(4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/asynch_receiver.md
ASYNCH_RECEIVER -- requirements
Module: asynch_receiver

Interface
REQ-001 SHALL have parameter DIVIDER, default 16'd5208, meaning clk cycles per bit (50 MHz / 9600 bit/s).
REQ-002 SHALL have port clk  input  1  system clock, all logic on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port D  input  1  serial line, asynchronous to clk, idle high.
REQ-005 SHALL have port data  output  8  last correctly received byte.
REQ-006 SHALL have port valid  output  1  one-cycle pulse when data is updated.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-008 SHALL have port parity_err  output  1  one-cycle pulse on parity mismatch.
REQ-009 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 SHALL synchronise D through two flip-flops to produce rx_s; all decisions SHALL use rx_s only.
REQ-011 SHALL implement the frame 8N1: start 0, 8 data bits LSB first, stop 1.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY (macro only) and STOP, in that order.
REQ-013 IDLE: SHALL hold tick_cnt=0 and bit_cnt=0; on rx_s falling edge (previous rx_s=1, current=0) SHALL go to START.
REQ-014 START: SHALL count to DIVIDER/2-1 (mid-bit); if rx_s=0 there SHALL go to DATA with tick_cnt=0; otherwise SHALL treat it as a glitch and return to IDLE with no output pulse.
REQ-015 DATA: every DIVIDER ticks SHALL shift rx_s into bit position bit_cnt of a shift register and increment bit_cnt; after the 8th sample SHALL go to PARITY (macro) or STOP.
REQ-016 STOP: after DIVIDER ticks SHALL sample rx_s, raise exactly one result pulse in the next cycle and return to IDLE.
REQ-017 rx_s=1 at the stop sample with no parity error SHALL raise valid=1 for one cycle and load data in the same cycle.
REQ-018 rx_s=0 at the stop sample SHALL raise frame_err; valid SHALL stay 0 and data SHALL hold its old value.
REQ-019 Line held low after a frame error (break) SHALL NOT start a new frame until rx_s has been seen high (falling-edge rule, REQ-013).
REQ-020 tick_cnt SHALL be 16 bits, compare with ==, and wrap to 0 at every bit boundary; bit_cnt SHALL be 4 bits.
REQ-021 data SHALL hold its value between frames; valid, frame_err and parity_err SHALL never be high for more than one cycle.

Reset
REQ-022 With rst_n=0 at posedge clk: state=IDLE, counters=0, data=8'h00, valid=frame_err=parity_err=busy=0, and synchroniser flops=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, the first falling edge SHALL start a fresh frame.

Configuration
REQ-024 With macro ASYNCH_RX_PARITY_EN defined: SHALL insert state PARITY (one bit period after DATA, even parity); a mismatch with a good stop bit SHALL pulse parity_err instead of valid; when both checks fail, frame_err and parity_err SHALL pulse together.
REQ-025 Without the macro: the frame SHALL be 8N1, PARITY SHALL be unreachable, and parity_err SHALL be tied to 0.

Structure
REQ-026 Package asynch_uart_pkg SHALL hold the DIVIDER default, DATA_BITS=8 and the state encoding; the existing sender SHALL be able to share it.
REQ-027 The two-flop synchroniser SHALL be the sub-module asynch_rx_sync (1-bit, reset value 1).

Verification (bench DIVIDER=16)
REQ-028 Send 8'hA5 8N1 -> one valid pulse with data=8'hA5 within 160 cycles of the start edge; no error pulses.
REQ-029 Send 8'h00 then 8'hFF back-to-back with no idle gap -> two valid pulses, data 8'h00 then 8'hFF.
REQ-030 Pulse D low for 4 cycles -> no pulse on any output, busy returns to 0 within 8 cycles.
REQ-031 Send 8'h3C with the stop bit low, then hold D low for 40 cycles -> one frame_err pulse, data unchanged, no new frame until D goes high.
REQ-032 Assert rst_n=0 during bit 3 -> outputs equal their reset values; the next 8'h5A frame is received correctly.
REQ-033 With ASYNCH_RX_PARITY_EN: 8'h01 with parity bit 0 -> parity_err pulse, no valid; with parity bit 1 -> valid, data=8'h01.
